// File: rtl/serial_byte_tx.sv
// -----------------------------------------------------------------------------
// serial_byte_tx
//
// Parallel-to-serial word transmitter. Words arrive over a valid/ready
// handshake into a one-word holding register. They are then shifted out
// MSB-first, one bit per clock, on so/so_en, which wire straight to the
// si/en inputs of the downstream serial shift stage. The holding register lets
// the next word be queued while the current one is still shifting, so with
// GAP = 0 consecutive words leave back-to-back with no idle cycle.
//
// Parameters:
//   WIDTH     bits per word (>= 2)
//   GAP       idle cycles forced between words, 0..15
//
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset; aborts any word in flight
//   din       word to transmit
//   din_valid din holds a word
//   din_ready holding register is empty (combinational, low during reset)
//   so        serial data, MSB first; 0 whenever so_en is low
//   so_en     so carries a valid bit this cycle
//   last      high with so_en on the final (LSB) bit of a word
//   busy      shifting, running a gap, or holding a queued word
// -----------------------------------------------------------------------------
module serial_byte_tx #(
  parameter int WIDTH = 8,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             so,
  output logic             so_en,
  output logic             last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST  = CW'(WIDTH - 1);
  localparam logic [3:0]    GCNT_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       gcnt_q, gcnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             so_q, so_d;
  logic             so_en_q, so_en_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             accept;
  logic             start;

  assign din_ready = ~hold_full_q & ~rst;
  assign accept    = din_valid & din_ready;

  assign so    = so_q;
  assign so_en = so_en_q;
  assign last  = last_q;
  assign busy  = busy_q;

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    gcnt_d      = gcnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    start       = 1'b0;

    case (state_q)
      S_IDLE: begin
        start = hold_full_q;
      end
      S_SHIFT: begin
        sr_d  = {sr_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (GAP == 0) begin
            // A queued word follows the last bit with no idle cycle.
            state_d = S_IDLE;
            start   = hold_full_q;
          end else begin
            state_d = S_GAP;
            gcnt_d  = '0;
          end
        end
      end
      S_GAP: begin
        gcnt_d = gcnt_q + 4'd1;
        if (gcnt_q == GCNT_LAST) begin
          gcnt_d  = '0;
          state_d = S_IDLE;
          // Starting straight out of the final gap cycle keeps the idle
          // stretch between words at exactly GAP cycles.
          start   = hold_full_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (start) begin
      sr_d        = hold_q;
      cnt_d       = '0;
      hold_full_d = 1'b0;
      state_d     = S_SHIFT;
    end

    // accept and start are mutually exclusive: din_ready is low while the
    // holding register is full, and start needs it full.
    if (accept) begin
      hold_d      = din;
      hold_full_d = 1'b1;
    end

    // Outputs are registered copies of what the next state will present.
    so_en_d = (state_d == S_SHIFT);
    so_d    = so_en_d & sr_d[WIDTH-1];
    last_d  = so_en_d & (cnt_d == CNT_LAST);
    busy_d  = (state_d != S_IDLE) | hold_full_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      gcnt_q      <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      so_q        <= 1'b0;
      so_en_q     <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      gcnt_q      <= gcnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      so_q        <= so_d;
      so_en_q     <= so_en_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: doc/serial_byte_tx.md
# serial_byte_tx

Parallel-to-serial byte transmitter that feeds the serial-in shift stage (`qb`). It accepts bytes over a valid/ready handshake and buffers one byte in a holding register. Each byte is shifted out MSB-first on `so`, one bit per clock, with `so_en` qualifying every bit. `so`/`so_en` connect directly to the downstream `si`/`en`. `last` marks the final bit of each byte.

## Interface
- `WIDTH`, default 8: bits per word; must be ≥ 2.
- `GAP`, default 0: idle cycles forced between words (`so_en`=0); range 0..15.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `din` input WIDTH: word to transmit.
- `din_valid` input 1: `din` is valid.
- `din_ready` output 1: holding register can accept a word.
- `so` output 1: serial data, MSB first; drives downstream `si`.
- `so_en` output 1: `so` carries a valid bit this cycle; drives downstream `en`.
- `last` output 1: high together with `so_en` on the final (LSB) bit of a word.
- `busy` output 1: a word is being shifted, a gap is running, or the holding register is full.

## Operation
- **Holding register (`hold`, `hold_full`)**
  - `din_ready = ~hold_full & ~rst`.
  - Transfer occurs at an edge where `din_valid & din_ready`: `hold <= din`, `hold_full <= 1`.
- **Shift register `sr` (WIDTH bits) and bit counter `cnt` (0..WIDTH-1).**
- **IDLE**
  - Entered on reset.
  - If `hold_full`: `sr <= hold`, `hold_full <= 0`, `cnt <= 0`, go to SHIFT.
- **SHIFT**
  - Registered outputs: `so = sr[WIDTH-1]`, `so_en = 1`, `last = (cnt == WIDTH-1)`.
  - Each edge: `sr <= sr << 1`, `cnt <= cnt + 1`.
  - On the edge leaving `cnt == WIDTH-1`:
    - if `GAP == 0` and `hold_full`: reload directly (`sr <= hold`, `cnt <= 0`, `hold_full <= 0`), stay in SHIFT;
    - else if `GAP > 0`: go to GAP with `gcnt <= 0`;
    - else: go to IDLE.
- **GAP**
  - `so_en = 0`; `gcnt` increments each cycle.
  - When `gcnt == GAP-1`, go to IDLE.
- **When `so_en` = 0:** `so` = 0 and `last` = 0.
- **Simultaneous events**
  - An incoming word and a `hold` → `sr` transfer never coincide, because `din_ready` is low while `hold_full` is set.
  - A new word may be accepted in any cycle of SHIFT or GAP once `hold` has emptied.
- **Reset**
  - Values: `so`=0, `so_en`=0, `last`=0, `busy`=0, `hold_full`=0, state IDLE, `cnt`=0, `gcnt`=0.
  - Reset mid-word aborts it: remaining bits and the held word are discarded, and `so_en` is 0 from the first edge with `rst` high.
  - `din_ready` is 0 while `rst` is high and 1 on the first cycle after.

## Timing
- **Outputs:** all outputs except `din_ready` are registered.
- **Latency:** word accepted at edge N → `hold_full` set after N → `sr` loaded at N+1 → first bit on `so` with `so_en`=1 during cycle N+1..N+2.
- **Word duration:** exactly WIDTH consecutive `so_en` cycles, then GAP cycles with `so_en`=0.
- **Throughput with `GAP`=0:** continuous `so_en` across words, provided the next word reaches `hold` at least one cycle before the last bit.
- **`busy`:** goes high the edge after acceptance. Goes low the edge after the last bit (GAP=0) or after the final gap cycle, when `hold` is empty.

## Test plan
- **Single word.** `din`=8'hB6, one-cycle valid → `so` = 1,0,1,1,0,1,1,0 on 8 consecutive `so_en` cycles, starting 1 cycle after acceptance. `last` high only on the 8th. Downstream shift stage captures 8'hB6.
- **Back-to-back, `GAP`=0.** Words 8'hB6 then 8'hFF presented continuously → 16 consecutive `so_en` cycles. `so` = B6 bits then eight 1s. `last` on cycles 8 and 16.
- **Backpressure.** Three words 8'h01, 8'h02, 8'h03 with `din_valid` held high → `din_ready` low whenever `hold_full`. All three are emitted in order. No word is lost or duplicated.
- **Gap.** `GAP`=2, two words 8'hA5, 8'h5A → exactly 2 cycles of `so_en`=0 between the 8-bit bursts.
- **Reset mid-word.** `rst` high for one cycle after the 3rd bit of 8'hB6 while 8'h3C is held → `so_en`=0 and `hold_full`=0 from the next edge, and 8'h3C is never transmitted. A new word sent after reset transmits normally.
- **Idle stability.** `din_valid`=0 for 20 cycles after reset → `so_en`=0, `so`=0, `busy`=0, `din_ready`=1 throughout.
